// File: rtl/bus_if_burst.sv
// Multiplexed 8-bit bus master: ADDR_BYTES address phases then 1..MAX_BURST data beats over 4-phase req/ack.
// Each phase takes >=2 cycles plus peripheral ack delay; a stalled phase is aborted by the TIMEOUT watchdog.
module bus_if_burst #(
  parameter int ADDR_BYTES = 2,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 255,
  localparam int LW = $clog2(MAX_BURST),
  localparam int AW = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_handshake_ack,
  output logic          bus_handshake_req,
  output logic [1:0]    bus_state,
  output logic          bus_last,
  input  logic [7:0]    bus_data_in,
  output logic [7:0]    bus_data_out,
  output logic          bus_output_enable,
  input  logic          memory_read,
  input  logic          memory_write,
  input  logic [AW-1:0] memory_addr,
  input  logic [LW-1:0] memory_len,
  input  logic [7:0]    memory_wdata,
  output logic [7:0]    memory_rdata,
  output logic          memory_beat,
  output logic          memory_done,
  output logic          memory_error
);
  localparam int IW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(ADDR_BYTES - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          req_q, req_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          beat_pls_q, beat_pls_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          complete;
  logic          expired;
  logic [7:0]    addr_byte;

  assign complete = (state_q != S_IDLE) && req_q && bus_handshake_ack;
  assign expired  = (TIMEOUT > 0) && (state_q != S_IDLE) && !complete && (wdog_q == WD_LIMIT);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    req_d      = req_q;
    wdog_d     = wdog_q;
    rdata_d    = rdata_q;
    beat_pls_d = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    if (state_q == S_IDLE) begin
      // A pending done/error pulse blocks re-trigger so a held request restarts one cycle later.
      if ((memory_read || memory_write) && !done_q && !error_q) begin
        addr_d  = memory_addr;
        len_d   = memory_len;
        wr_d    = !memory_read;
        idx_d   = '0;
        wdog_d  = '0;
        state_d = S_ADDR;
      end
    end else if (complete) begin
      req_d  = 1'b0;
      wdog_d = '0;
      if (state_q == S_ADDR) begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          beat_d  = '0;
          state_d = S_DATA;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        beat_pls_d = 1'b1;
        if (!wr_q) rdata_d = bus_data_in;
        if (beat_q == len_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end else if (expired) begin
      req_d   = 1'b0;
      wdog_d  = '0;
      error_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      // Waiting for ack to fall first keeps every phase a full 4-phase cycle.
      if (!req_q && !bus_handshake_ack) req_d = 1'b1;
      if (TIMEOUT > 0) wdog_d = wdog_q + 1'b1;
    end
  end

  always_comb begin
    bus_state         = 2'b00;
    bus_last          = 1'b0;
    bus_output_enable = 1'b0;
    bus_data_out      = 8'h00;
    addr_byte         = 8'h00;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (idx_q == IW'(k)) addr_byte = addr_q[8*k +: 8];
    end
    case (state_q)
      S_ADDR: begin
        bus_output_enable = 1'b1;
        bus_data_out      = addr_byte;
        bus_state         = (idx_q == '0) ? 2'b00 : 2'b01;
      end
      S_DATA: begin
        bus_state         = {1'b1, wr_q};
        bus_last          = (beat_q == len_q);
        bus_output_enable = wr_q;
        bus_data_out      = wr_q ? memory_wdata : 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      req_q      <= 1'b0;
      wdog_q     <= '0;
      rdata_q    <= 8'h00;
      beat_pls_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      req_q      <= req_d;
      wdog_q     <= wdog_d;
      rdata_q    <= rdata_d;
      beat_pls_q <= beat_pls_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus_handshake_req = req_q;
  assign memory_rdata      = rdata_q;
  assign memory_beat       = beat_pls_q;
  assign memory_done       = done_q;
  assign memory_error      = error_q;
endmodule
